// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register offsets,
// handshake state encodings and the VEC valid-bit position.
package irq_ctrl_pkg;

  localparam logic [2:0] REG_PEND = 3'd0;
  localparam logic [2:0] REG_MASK = 3'd1;
  localparam logic [2:0] REG_MODE = 3'd2;
  localparam logic [2:0] REG_VEC  = 3'd3;
  localparam logic [2:0] REG_EOI  = 3'd4;

  localparam int VEC_VALID_BIT = 31;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

endpackage

// File: rtl/irq_ctrl_prio_enc.sv
// Lowest-index-wins priority encoder producing {valid, id}; index 0 is
// the highest-priority request.
module irq_prio_enc
  import irq_ctrl_pkg::*;
#(
  parameter int NSRC = 6,
  parameter int IDW  = 4
) (
  input  logic [NSRC-1:0] req,
  output logic            valid,
  output logic [IDW-1:0]  id
);

  // Scan from the top down so the lowest set index is the last assignment.
  always_comb begin
    valid = 1'b0;
    id    = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        id    = IDW'(i);
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: pending latch, mask, fixed priority and the
// request/ack/EOI handshake. Define IRQ_SYNC_EN to add 2-flop src synchronizers.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int NSRC = 6,
  parameter int IDW  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [29:0]     Addr,
  input  logic            WE,
  input  logic [31:0]     Din,
  output logic [31:0]     Dout,
  input  logic [NSRC-1:0] src,
  input  logic            int_ack,
  output logic            irq,
  output logic [NSRC-1:0] hwint
);

  state_t          state, state_n;
  logic [NSRC-1:0] pend, pend_n, mask, mode;
  logic [NSRC-1:0] src_smp, src_hist, edge_set, w1c, ack_clr, active;
  logic [IDW-1:0]  svc_id, win_id;
  logic            win_vld, ack_take;
  logic            wr_pend, wr_mask, wr_mode, wr_eoi;
  logic [2:0]      reg_sel;
  logic [31:0]     vec;
  logic            unused_bits;

`ifdef IRQ_SYNC_EN
  logic [NSRC-1:0] sync_q1, sync_q2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= src;
      sync_q2 <= sync_q1;
    end
  end

  assign src_smp = sync_q2;
`else
  assign src_smp = src;
`endif

  assign reg_sel     = Addr[2:0];
  assign unused_bits = ^{Addr[29:3], Din[31:NSRC]};
  assign wr_pend     = WE && (reg_sel == REG_PEND);
  assign wr_mask     = WE && (reg_sel == REG_MASK);
  assign wr_mode     = WE && (reg_sel == REG_MODE);
  assign wr_eoi      = WE && (reg_sel == REG_EOI);

  assign active = pend & mask;
  assign hwint  = active;

  irq_prio_enc #(.NSRC(NSRC), .IDW(IDW)) u_prio (
    .req   (active),
    .valid (win_vld),
    .id    (win_id)
  );

  assign ack_take = (state == ST_REQ) && int_ack && win_vld;
  assign edge_set = src_smp & ~src_hist;
  assign w1c      = wr_pend ? Din[NSRC-1:0] : '0;

  always_comb begin
    ack_clr = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (ack_take && (win_id == IDW'(i))) ack_clr[i] = 1'b1;
    end
  end

  // Level bits follow the line; edge bits hold, clear on W1C/ack, and a new edge wins.
  assign pend_n = (~mode & src_smp) | (mode & ((pend & ~w1c & ~ack_clr) | edge_set));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend     <= '0;
      mask     <= '0;
      mode     <= '0;
      src_hist <= '0;
      svc_id   <= '0;
    end else begin
      pend     <= pend_n;
      src_hist <= src_smp;
      if (wr_mask)  mask   <= Din[NSRC-1:0];
      if (wr_mode)  mode   <= Din[NSRC-1:0];
      if (ack_take) svc_id <= win_id;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:    if (|active) state_n = ST_REQ;
      ST_REQ: begin
        if (!win_vld)     state_n = ST_IDLE;
        else if (int_ack) state_n = ST_SERVICE;
      end
      ST_SERVICE: if (wr_eoi) state_n = ST_IDLE;
      default:    state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    irq = 1'b0;
    vec = '0;
    case (state)
      ST_REQ: begin
        irq                = 1'b1;
        vec[VEC_VALID_BIT] = win_vld;
        vec[IDW-1:0]       = win_id;
      end
      ST_SERVICE: begin
        vec[VEC_VALID_BIT] = 1'b1;
        vec[IDW-1:0]       = svc_id;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (reg_sel)
      REG_PEND: Dout = 32'(pend);
      REG_MASK: Dout = 32'(mask);
      REG_MODE: Dout = 32'(mode);
      REG_VEC:  Dout = vec;
      default:  Dout = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard bench for irq_ctrl: a behavioural model predicts irq/hwint/Dout
// each cycle; a monitor compares on the falling edge.
module tb_irq_ctrl;

  localparam int NSRC = 6;
  localparam int IDW  = 4;
`ifdef IRQ_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [29:0]     Addr;
  logic            WE;
  logic [31:0]     Din;
  logic [31:0]     Dout;
  logic [NSRC-1:0] src;
  logic            int_ack;
  logic            irq;
  logic [NSRC-1:0] hwint;

  int checks = 0;
  int errors = 0;

  always #10 clk = ~clk;

  irq_ctrl #(.NSRC(NSRC), .IDW(IDW)) dut (
    .clk     (clk),
    .rst     (rst),
    .Addr    (Addr),
    .WE      (WE),
    .Din     (Din),
    .Dout    (Dout),
    .src     (src),
    .int_ack (int_ack),
    .irq     (irq),
    .hwint   (hwint)
  );

  typedef struct {
    logic            irq_e;
    logic [NSRC-1:0] hw_e;
    logic [31:0]     dout_e;
    logic [2:0]      a;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: phase 0 = idle, 1 = requesting, 2 = in service.
  bit [NSRC-1:0] m_pend, m_mask, m_mode, m_hist, m_s1, m_s2;
  int            m_phase;
  int            m_svc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int first_set(input bit [NSRC-1:0] v);
    for (int i = 0; i < NSRC; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic void model_reset();
    m_pend = '0; m_mask = '0; m_mode = '0; m_hist = '0;
    m_s1 = '0; m_s2 = '0; m_phase = 0; m_svc = 0;
  endfunction

  function automatic void model_step();
    bit [NSRC-1:0] s, np, act;
    int w;
    logic [2:0] a;
    if (!rst) begin
      model_reset();
      return;
    end
`ifdef IRQ_SYNC_EN
    s = m_s2;
`else
    s = src;
`endif
    act = m_pend & m_mask;
    w   = first_set(act);
    a   = Addr[2:0];
    for (int i = 0; i < NSRC; i++) begin
      if (!m_mode[i]) np[i] = s[i];
      else begin
        np[i] = m_pend[i];
        if (WE && a == 3'd0 && Din[i]) np[i] = 1'b0;
        if (m_phase == 1 && int_ack && w == i) np[i] = 1'b0;
        if (s[i] && !m_hist[i]) np[i] = 1'b1;
      end
    end
    if (m_phase == 0) begin
      if (act != 0) m_phase = 1;
    end else if (m_phase == 1) begin
      if (act == 0) m_phase = 0;
      else if (int_ack) begin
        m_phase = 2;
        m_svc   = w;
      end
    end else if (WE && a == 3'd4) m_phase = 0;
    if (WE && a == 3'd1) m_mask = Din[NSRC-1:0];
    if (WE && a == 3'd2) m_mode = Din[NSRC-1:0];
    m_hist = s;
    m_s2   = m_s1;
    m_s1   = src;
    m_pend = np;
  endfunction

  function automatic logic [31:0] exp_dout(input logic [2:0] a);
    int w;
    logic [31:0] v;
    w = first_set(m_pend & m_mask);
    v = '0;
    if (m_phase == 1 && w >= 0) v = {1'b1, 27'd0, 4'(w)};
    else if (m_phase == 2)      v = {1'b1, 27'd0, 4'(m_svc)};
    case (a)
      3'd0:    return 32'(m_pend);
      3'd1:    return 32'(m_mask);
      3'd2:    return 32'(m_mode);
      3'd3:    return v;
      default: return 32'd0;
    endcase
  endfunction

  task automatic cyc(input logic [NSRC-1:0] s, input logic we_i, input logic [2:0] a,
                     input logic [31:0] d, input logic ack_i);
    exp_t e;
    @(posedge clk);
    model_step();
    #1;
    src = s; WE = we_i; Addr = {27'($urandom), a}; Din = d; int_ack = ack_i;
    e.irq_e  = (m_phase == 1);
    e.hw_e   = m_pend & m_mask;
    e.dout_e = exp_dout(a);
    e.a      = a;
    exp_q.push_back(e);
  endtask

  task automatic settle(input logic [NSRC-1:0] s, input logic [2:0] a);
    repeat (SYNC_LAT) cyc(s, 1'b0, a, 32'd0, 1'b0);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_irq", 32'(irq), 32'(e.irq_e));
        chk("sb_hwint", 32'(hwint), 32'(e.hw_e));
        chk($sformatf("sb_dout_a%0d", e.a), Dout, e.dout_e);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    bit [NSRC-1:0] rs;
    rst = 1'b0; src = '0; Addr = '0; WE = 1'b0; Din = '0; int_ack = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    cyc('0, 1'b0, 3'd3, 32'd0, 1'b0);
    cyc('0, 1'b0, 3'd0, 32'd0, 1'b0);

    // Level source 0
    cyc(6'h00, 1'b1, 3'd1, 32'h01, 1'b0);
    cyc(6'h01, 1'b0, 3'd3, 32'd0, 1'b0);
    settle(6'h01, 3'd3);
    cyc(6'h01, 1'b0, 3'd3, 32'd0, 1'b0);
    cyc(6'h01, 1'b0, 3'd3, 32'd0, 1'b0);
    #1 chk("lvl_irq", 32'(irq), 32'd1);
    chk("lvl_vec", Dout, 32'h8000_0000);
    cyc(6'h00, 1'b0, 3'd3, 32'd0, 1'b0);
    settle(6'h00, 3'd3);
    cyc(6'h00, 1'b0, 3'd3, 32'd0, 1'b0);
    cyc(6'h00, 1'b0, 3'd3, 32'd0, 1'b0);
    #1 chk("lvl_drop_irq", 32'(irq), 32'd0);

    // Edge priority and handshake
    cyc(6'h00, 1'b1, 3'd2, 32'h3F, 1'b0);
    cyc(6'h00, 1'b1, 3'd1, 32'h3F, 1'b0);
    cyc(6'h0A, 1'b0, 3'd3, 32'd0, 1'b0);
    cyc(6'h00, 1'b0, 3'd3, 32'd0, 1'b0);
    settle(6'h00, 3'd3);
    cyc(6'h00, 1'b0, 3'd3, 32'd0, 1'b1);
    #1 chk("edge_vec1", Dout, 32'h8000_0001);
    cyc(6'h00, 1'b0, 3'd0, 32'd0, 1'b0);
    #1 chk("ack_pend", Dout, 32'h08);
    chk("svc_irq", 32'(irq), 32'd0);
    cyc(6'h00, 1'b1, 3'd4, 32'd0, 1'b0);
    cyc(6'h00, 1'b0, 3'd3, 32'd0, 1'b0);
    cyc(6'h00, 1'b0, 3'd3, 32'd0, 1'b0);
    #1 chk("eoi_vec3", Dout, 32'h8000_0003);
    cyc(6'h00, 1'b0, 3'd3, 32'd0, 1'b1);
    cyc(6'h00, 1'b1, 3'd4, 32'd0, 1'b0);
    cyc(6'h00, 1'b0, 3'd0, 32'd0, 1'b0);
    cyc(6'h00, 1'b0, 3'd0, 32'd0, 1'b1);
    cyc(6'h00, 1'b0, 3'd0, 32'd0, 1'b0);
    #1 chk("idle_ack_pend", Dout, 32'h0);

    // W1C racing a new edge, EOI in REQ, mask-off in REQ
    repeat (SYNC_LAT) cyc(6'h04, 1'b0, 3'd0, 32'd0, 1'b0);
    cyc(6'h04, 1'b1, 3'd0, 32'h04, 1'b0);
    cyc(6'h04, 1'b0, 3'd0, 32'd0, 1'b0);
    #1 chk("w1c_race", Dout, 32'h04);
    cyc(6'h04, 1'b1, 3'd4, 32'd0, 1'b0);
    cyc(6'h04, 1'b1, 3'd1, 32'd0, 1'b0);
    #1 chk("eoi_in_req_irq", 32'(irq), 32'd1);
    cyc(6'h04, 1'b0, 3'd3, 32'd0, 1'b0);
    cyc(6'h04, 1'b0, 3'd3, 32'd0, 1'b0);
    #1 chk("mask_off_irq", 32'(irq), 32'd0);

    // Asynchronous reset while requesting with PEND=04
    cyc(6'h04, 1'b1, 3'd1, 32'h04, 1'b0);
    cyc(6'h04, 1'b0, 3'd0, 32'd0, 1'b0);
    cyc(6'h04, 1'b0, 3'd3, 32'd0, 1'b0);
    #1 chk("pre_rst_irq", 32'(irq), 32'd1);
    @(negedge clk);
    #1 rst = 1'b0;
    model_reset();
    #1 chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_hwint", 32'(hwint), 32'd0);
    for (int a = 0; a < 4; a++) begin
      Addr = 30'(a);
      #1 chk($sformatf("rst_reg%0d", a), Dout, 32'd0);
    end
    rst = 1'b1;
    cyc(6'h00, 1'b1, 3'd4, 32'd0, 1'b0);
    cyc(6'h00, 1'b0, 3'd3, 32'd0, 1'b0);
    #1 chk("post_rst_vec", Dout, 32'd0);

    // Randomized traffic
    rs = '0;
    for (int n = 0; n < 3000; n++) begin
      logic       we_r, ack_r;
      logic [2:0] a_r;
      if ($urandom_range(3) == 0) rs = NSRC'($urandom);
      we_r  = ($urandom_range(3) == 0);
      a_r   = 3'($urandom);
      ack_r = ($urandom_range(3) == 0);
      cyc(rs, we_r, a_r, $urandom, ack_r);
    end
    cyc('0, 1'b0, 3'd0, 32'd0, 1'b0);
    @(negedge clk);
    #1 chk("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
